logen_vsel_cal: RTL
===================

# logen_vsel_cal

Parametrised successor to the LOGEN LDO process calibration. Repeatedly enables the ring-oscillator counter for a programmable window and averages 1/2/4/8 readings. The averaged count is mapped through NSEG programmable boundaries to select `ldo_logen_vsel`. Sits between the register bank and the LOGEN analog counter/LDO in the logen clock domain.

## Interface
- NSEG, 5: number of vsel segments (2..8); NSEG-1 boundaries
- CNTR_W, 14: width of `a2d_ncntr`
- VAL_LSB, 4: LSB of the count field taken from `a2d_ncntr`
- VAL_W, 6: width of the count field / boundaries; VAL_LSB+VAL_W <= CNTR_W
- VSEL_W, 3: LDO vsel code width
- WIN_W, 5: window-length register width
- VSEL_RST, 3'b010: vsel reset value (950 mV)
- clk  in  1  logen clock
- rstn  in  1  asynchronous active-low reset
- logen_en  in  1  calibration request; asynchronous, synchronised internally
- rg_logen_cal_bypass  in  1  force `ldo_logen_vsel` = `rg_logen_vsel_man`
- rg_logen_vsel_man  in  VSEL_W  manual vsel
- rg_logen_win_m1  in  WIN_W  counter-enable window minus 1, in cycles
- rg_logen_avg_log2  in  2  readings per calibration = 2^value
- rg_logen_vsel_seg  in  NSEG*VSEL_W  vsel per segment; segment i at [i*VSEL_W +: VSEL_W]
- rg_logen_cntr_bound  in  (NSEG-1)*VAL_W  upper bound per segment; bound i at [i*VAL_W +: VAL_W]
- a2d_ncntr  in  CNTR_W  analog counter result
- cntr_rstn  out  1  counter reset, active low
- cntr_en  out  1  counter enable
- cntr_datasyn  out  1  counter data-sync strobe
- logen_cntr_curr  out  VAL_W  last averaged count
- ldo_logen_vsel  out  VSEL_W  LDO voltage select
- cal_busy  out  1  high whenever FSM not IDLE
- cal_done  out  1  one-cycle pulse on successful update

## Operation
- `logen_en` passes through a 3-flop shift register. Start = rising edge between flops 2 and 3.
- FSM states: IDLE, RST, EN_PRE, EN, EN_POST, SYN, ACC, UPDATE.
- State transitions:
  - IDLE → RST on start.
  - RST → EN_PRE → EN.
  - EN holds for rg_logen_win_m1+1 cycles (window counter 0..win_m1), then → EN_POST.
  - EN_POST → SYN → ACC.
  - ACC → RST if readings done < 2^avg_log2, else → UPDATE.
  - UPDATE → IDLE.
- Output assertion:
  - cntr_rstn is low exactly during RST cycles.
  - cntr_en is high exactly during EN cycles.
  - cntr_datasyn is high exactly during SYN cycles.
- Averaging:
  - In ACC, `a2d_ncntr[VAL_LSB +: VAL_W]` is added to a VAL_W+3 bit accumulator. The accumulator clears on IDLE→RST; it cannot overflow.
  - In UPDATE, avg = acc >> rg_logen_avg_log2 (truncating). logen_cntr_curr ← avg, and cal_done pulses.
- Segment map: the chosen segment is the lowest i (0..NSEG-2) with avg <= bound i; else segment NSEG-1. In UPDATE, vsel ← seg code, unless bypass is set.
- Bypass: vsel ← rg_logen_vsel_man every cycle, regardless of state. The FSM still runs and logen_cntr_curr still updates.
- Abort: a synchronised `logen_en` low in any non-IDLE state forces the next state to IDLE. Effects:
  - cntr_en and cntr_datasyn drop next cycle; cntr_rstn returns high.
  - No update and no cal_done; vsel and logen_cntr_curr are held.
- Registers are sampled live; software must not change them while cal_busy is high.

## Timing
- Reset values:
  - cntr_rstn=1, cntr_en=0, cntr_datasyn=0, cal_busy=0, cal_done=0.
  - logen_cntr_curr=0, ldo_logen_vsel=VSEL_RST.
  - FSM=IDLE, synchroniser=0.
- Start → first RST cycle: 1 cycle after the detected edge. Total is 3 clk from the `logen_en` rising edge (setup met).
- One reading lasts W+5 cycles, where W = win_m1+1.
- A calibration lasts N*(W+5)+1 cycles from RST entry to the UPDATE cycle, where N = 2^avg_log2.
- vsel and cal_done become visible 1 cycle after UPDATE.
- Once back in IDLE, a new rising edge is required to start again. With the macro below, a timer restart is also permitted.

## Configuration
- Macro `LOGEN_VSEL_PERIODIC_RECAL_EN`.
- Defined:
  - Adds input `rg_logen_recal_period` [15:0].
  - In IDLE with synchronised `logen_en`=1 and period≠0, a 16-bit timer counts cycles from IDLE entry. When it reaches the period it triggers start.
  - The timer clears on leaving IDLE.
  - Period=0 disables periodic restart.
- Undefined: the port is absent; only the `logen_en` rising edge starts a calibration.

## Structure
- Package `logen_cal_pkg` holds:
  - the state enum (3-bit);
  - `LOGEN_VSEL_DEFAULT`;
  - the accumulator-extra-bits constant (3).
- Sub-module `logen_seg_map` is combinational, parametrised by NSEG/VAL_W/VSEL_W. It takes avg, bounds and segs and returns the vsel code (priority encoder).

## Test plan
Default parameters; bounds 10,20,30,40; segs 1,2,3,4,5.
- Reset, then win_m1=7, avg_log2=0, `a2d_ncntr`=0x0190 (field 25), `logen_en` raised:
  - cntr_rstn low 1 cycle; cntr_en high 8 cycles; datasyn 1 cycle.
  - vsel=3, logen_cntr_curr=25, cal_done once.
  - cal_busy high for 14 cycles.
- avg_log2=2, field sequence 9,11,10,12 → avg 10 → vsel=1 (boundary inclusive). Field 41 → vsel=5. Field 40 → vsel=4.
- Bypass=1, man=6, mid-calibration → vsel=6 next cycle and stays 6 after UPDATE. logen_cntr_curr still updates.
- `logen_en` dropped during EN → cntr_en low within 4 cycles, FSM IDLE, no cal_done, vsel unchanged.
- Asynchronous reset asserted mid-EN → all outputs return to reset values immediately, vsel=2.
- With `LOGEN_VSEL_PERIODIC_RECAL_EN`, period=100, `logen_en` held high → a new calibration starts every 100 IDLE cycles. Period=0 → exactly one calibration.

Source files
------------

// File: rtl/logen_cal_pkg.sv
// Shared types and constants for the LOGEN LDO vsel calibration block.
package logen_cal_pkg;

    // Calibration sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RST     = 3'd1,
        ST_EN_PRE  = 3'd2,
        ST_EN      = 3'd3,
        ST_EN_POST = 3'd4,
        ST_SYN     = 3'd5,
        ST_ACC     = 3'd6,
        ST_UPDATE  = 3'd7
    } cal_state_t;

    // Power-on LDO vsel code (950 mV)
    localparam logic [2:0] LOGEN_VSEL_DEFAULT = 3'b010;

    // Extra accumulator bits so that up to 8 full-scale readings fit
    localparam int ACC_XTRA_W = 3;

endpackage

// File: rtl/logen_seg_map.sv
// Combinational segment map: picks the lowest segment whose upper bound
// is >= avg, falling back to the last segment when no bound matches.
module logen_seg_map
    import logen_cal_pkg::*;
#(
    parameter int NSEG   = 5,
    parameter int VAL_W  = 6,
    parameter int VSEL_W = 3
) (
    input  logic [VAL_W-1:0]          avg,
    input  logic [(NSEG-1)*VAL_W-1:0] bounds,
    input  logic [NSEG*VSEL_W-1:0]    segs,
    output logic [VSEL_W-1:0]         vsel
);

    logic [NSEG-2:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < NSEG - 1; gi++) begin : g_cmp
            assign hit[gi] = (avg <= bounds[gi*VAL_W +: VAL_W]);
        end
    endgenerate

    // Priority encode: lowest matching boundary wins
    always_comb begin
        vsel = segs[(NSEG-1)*VSEL_W +: VSEL_W];
        for (int i = NSEG - 2; i >= 0; i--) begin
            if (hit[i]) begin
                vsel = segs[i*VSEL_W +: VSEL_W];
            end
        end
    end

endmodule

// File: rtl/logen_vsel_cal.sv
// LOGEN LDO process calibration: runs the ring-oscillator counter for a
// programmable window, averages 1/2/4/8 readings and maps the average onto
// a vsel code through programmable boundaries.
// Optional feature macro: LOGEN_VSEL_PERIODIC_RECAL_EN (timer-driven restart
// while logen_en stays high; adds input rg_logen_recal_period).
module logen_vsel_cal
    import logen_cal_pkg::*;
#(
    parameter int                NSEG     = 5,
    parameter int                CNTR_W   = 14,
    parameter int                VAL_LSB  = 4,
    parameter int                VAL_W    = 6,
    parameter int                VSEL_W   = 3,
    parameter int                WIN_W    = 5,
    parameter logic [VSEL_W-1:0] VSEL_RST = VSEL_W'(LOGEN_VSEL_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       logen_en,
    input  logic                       rg_logen_cal_bypass,
    input  logic [VSEL_W-1:0]          rg_logen_vsel_man,
    input  logic [WIN_W-1:0]           rg_logen_win_m1,
    input  logic [1:0]                 rg_logen_avg_log2,
    input  logic [NSEG*VSEL_W-1:0]     rg_logen_vsel_seg,
    input  logic [(NSEG-1)*VAL_W-1:0]  rg_logen_cntr_bound,
`ifdef LOGEN_VSEL_PERIODIC_RECAL_EN
    input  logic [15:0]                rg_logen_recal_period,
`endif
    input  logic [CNTR_W-1:0]          a2d_ncntr,
    output logic                       cntr_rstn,
    output logic                       cntr_en,
    output logic                       cntr_datasyn,
    output logic [VAL_W-1:0]           logen_cntr_curr,
    output logic [VSEL_W-1:0]          ldo_logen_vsel,
    output logic                       cal_busy,
    output logic                       cal_done
);

    localparam int ACC_W = VAL_W + ACC_XTRA_W;

    cal_state_t          state_reg, state_next;
    logic [2:0]          sync_reg;
    logic [WIN_W-1:0]    win_cnt_reg;
    logic [3:0]          rd_cnt_reg;
    logic [ACC_W-1:0]    acc_reg;
    logic [VAL_W-1:0]    curr_reg;
    logic [VSEL_W-1:0]   vsel_reg;
    logic                done_reg;

    logic                en_sync;
    logic                edge_start;
    logic                start;
    logic                win_last;
    logic                rd_last;
    logic [3:0]          rd_total;
    logic                do_update;
    logic [VAL_W-1:0]    field;
    logic [ACC_W-1:0]    acc_shift;
    logic [VAL_W-1:0]    avg;
    logic [VSEL_W-1:0]   seg_vsel;
    logic                unused_cntr_bits;

    // Only the count field of the analog counter is meaningful
    assign unused_cntr_bits = ^a2d_ncntr;

    assign en_sync    = sync_reg[1];
    assign edge_start = sync_reg[1] & ~sync_reg[2];
    assign field      = a2d_ncntr[VAL_LSB +: VAL_W];
    assign win_last   = (win_cnt_reg == rg_logen_win_m1);
    assign rd_total   = 4'd1 << rg_logen_avg_log2;
    assign rd_last    = ((rd_cnt_reg + 4'd1) >= rd_total);
    assign acc_shift  = acc_reg >> rg_logen_avg_log2;
    assign avg        = acc_shift[VAL_W-1:0];
    // A request dropped during the UPDATE cycle also suppresses the update
    assign do_update  = (state_reg == ST_UPDATE) && en_sync;

`ifdef LOGEN_VSEL_PERIODIC_RECAL_EN
    logic [15:0] timer_reg;
    logic        timer_run;
    logic        recal_start;

    assign timer_run   = (state_reg == ST_IDLE) && en_sync && (rg_logen_recal_period != 16'd0);
    assign recal_start = timer_run && (timer_reg == rg_logen_recal_period - 16'd1);
    assign start       = edge_start | recal_start;

    // Idle timer: counts IDLE cycles while enabled, clears otherwise
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer_reg <= 16'd0;
        end else if (timer_run) begin
            timer_reg <= timer_reg + 16'd1;
        end else begin
            timer_reg <= 16'd0;
        end
    end
`else
    assign start = edge_start;
`endif

    // Request synchroniser (3 flops; the last one only serves edge detection)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_reg <= 3'b000;
        end else begin
            sync_reg <= {sync_reg[1:0], logen_en};
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic; a dropped request aborts from any busy state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (start) state_next = ST_RST;
            ST_RST:      state_next = ST_EN_PRE;
            ST_EN_PRE:   state_next = ST_EN;
            ST_EN:       if (win_last) state_next = ST_EN_POST;
            ST_EN_POST:  state_next = ST_SYN;
            ST_SYN:      state_next = ST_ACC;
            ST_ACC:      state_next = rd_last ? ST_UPDATE : ST_RST;
            ST_UPDATE:   state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
        if ((state_reg != ST_IDLE) && !en_sync) begin
            state_next = ST_IDLE;
        end
    end

    // FSM outputs decoded straight from the state register
    always_comb begin
        cntr_rstn    = (state_reg != ST_RST);
        cntr_en      = (state_reg == ST_EN);
        cntr_datasyn = (state_reg == ST_SYN);
        cal_busy     = (state_reg != ST_IDLE);
    end

    // Window counter runs 0..win_m1 during EN and rests at zero elsewhere
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_cnt_reg <= '0;
        end else if (state_reg == ST_EN) begin
            win_cnt_reg <= win_cnt_reg + 1'b1;
        end else begin
            win_cnt_reg <= '0;
        end
    end

    // Accumulator and reading counter, cleared when a calibration starts
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_reg    <= '0;
            rd_cnt_reg <= 4'd0;
        end else if ((state_reg == ST_IDLE) && (state_next == ST_RST)) begin
            acc_reg    <= '0;
            rd_cnt_reg <= 4'd0;
        end else if (state_reg == ST_ACC) begin
            acc_reg    <= acc_reg + {{ACC_XTRA_W{1'b0}}, field};
            rd_cnt_reg <= rd_cnt_reg + 4'd1;
        end
    end

    logen_seg_map #(
        .NSEG   (NSEG),
        .VAL_W  (VAL_W),
        .VSEL_W (VSEL_W)
    ) u_seg_map (
        .avg    (avg),
        .bounds (rg_logen_cntr_bound),
        .segs   (rg_logen_vsel_seg),
        .vsel   (seg_vsel)
    );

    // Result registers: average, done pulse and vsel (bypass overrides always)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            curr_reg <= '0;
            done_reg <= 1'b0;
            vsel_reg <= VSEL_RST;
        end else begin
            done_reg <= do_update;
            if (do_update) begin
                curr_reg <= avg;
            end
            if (rg_logen_cal_bypass) begin
                vsel_reg <= rg_logen_vsel_man;
            end else if (do_update) begin
                vsel_reg <= seg_vsel;
            end
        end
    end

    assign logen_cntr_curr = curr_reg;
    assign ldo_logen_vsel  = vsel_reg;
    assign cal_done        = done_reg;

endmodule
